// File: rtl/regfile_sb.sv
// Architectural GPR/HI/LO register file with write-through bypass on both read
// ports and a per-register pending-write scoreboard that drives the issue stall.
module regfile_sb #(
  parameter int NREG = 32,
  parameter int CNTW = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      w_regwrite,
  input  logic [$clog2(NREG)-1:0]   w_reg_waddr,
  input  logic [31:0]               w_reg_wdata,
  input  logic                      w_hi_wen,
  input  logic                      w_lo_wen,
  input  logic [31:0]               w_hi_wdata,
  input  logic [31:0]               w_lo_wdata,
  input  logic [$clog2(NREG)-1:0]   raddr1,
  input  logic [$clog2(NREG)-1:0]   raddr2,
  output logic [31:0]               rdata1,
  output logic [31:0]               rdata2,
  output logic [31:0]               hi_rdata,
  output logic [31:0]               lo_rdata,
  input  logic                      issue_valid,
  input  logic                      issue_regwrite,
  input  logic [$clog2(NREG)-1:0]   issue_waddr,
  input  logic                      use_rs,
  input  logic                      use_rt,
  output logic                      stall,
  input  logic                      flush
);

  localparam int AW = $clog2(NREG);
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [31:0]     gpr [NREG];
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic [CNTW-1:0] cnt [NREG];

  logic            ret1, ret2, retw;
  logic            rs_haz, rt_haz, waw_full;
  logic            accept;
  logic [NREG-1:0] inc_v;
  logic [NREG-1:0] dec_v;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) gpr[r] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (w_regwrite && (w_reg_waddr != '0)) gpr[w_reg_waddr] <= w_reg_wdata;
      if (w_hi_wen) hi_q <= w_hi_wdata;
      if (w_lo_wen) lo_q <= w_lo_wdata;
    end
  end

  assign rdata1   = (raddr1 == '0) ? '0 :
                    (w_regwrite && (w_reg_waddr == raddr1)) ? w_reg_wdata : gpr[raddr1];
  assign rdata2   = (raddr2 == '0) ? '0 :
                    (w_regwrite && (w_reg_waddr == raddr2)) ? w_reg_wdata : gpr[raddr2];
  assign hi_rdata = w_hi_wen ? w_hi_wdata : hi_q;
  assign lo_rdata = w_lo_wen ? w_lo_wdata : lo_q;

  // A register whose last outstanding write is landing this cycle is served by
  // the bypass, so it does not block issue.
  assign ret1 = w_regwrite && (w_reg_waddr == raddr1)      && (cnt[raddr1] == CNT_ONE);
  assign ret2 = w_regwrite && (w_reg_waddr == raddr2)      && (cnt[raddr2] == CNT_ONE);
  assign retw = w_regwrite && (w_reg_waddr == issue_waddr) && (cnt[issue_waddr] == CNT_ONE);

  assign rs_haz   = use_rs && (cnt[raddr1] != '0) && !ret1;
  assign rt_haz   = use_rt && (cnt[raddr2] != '0) && !ret2;
  assign waw_full = issue_regwrite && (cnt[issue_waddr] == CNT_MAX) && !retw;

  // Issue handshake: an instruction is taken on the edge where issue_valid=1,
  // stall=0 and flush=0; otherwise decode keeps presenting it.
  assign stall  = issue_valid && (rs_haz || rt_haz || waw_full);
  assign accept = issue_valid && !stall && !flush;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_v[r] = accept && issue_regwrite && (issue_waddr == AW'(r));
      dec_v[r] = w_regwrite && (w_reg_waddr == AW'(r)) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_v[r] && !dec_v[r])      cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec_v[r] && !inc_v[r]) cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

endmodule
